lsu_split: RTL and testbench



---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_split.sv | 138 +++++++++++++
 tb/tb_lsu_split.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and lane-mask helper for lsu_split
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_RESP
    } lsu_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/write-lane shifting and load assembly with sign/zero extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_beat0,
    input  logic [31:0] i_beat1,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_wdata_lo,
    output logic [31:0] o_wdata_hi,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_be_wide;
    logic [63:0] w_wd_wide;
    logic [31:0] w_rd;

    // The upper halves of the 64-bit shifts are exactly the second-beat lanes.
    assign w_be_wide  = {4'b0000, lane_mask(i_size)} << i_off;
    assign w_wd_wide  = {32'd0, i_wdata} << {i_off, 3'b000};
    assign o_be_lo    = w_be_wide[3:0];
    assign o_be_hi    = w_be_wide[7:4];
    assign o_wdata_lo = w_wd_wide[31:0];
    assign o_wdata_hi = w_wd_wide[63:32];
    assign w_rd       = 32'({i_beat1, i_beat0} >> {i_off, 3'b000});

    always_comb begin
        o_rdata = w_rd;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{~i_unsigned & w_rd[7]}}, w_rd[7:0]};
            SZ_HALF: o_rdata = {{16{~i_unsigned & w_rd[15]}}, w_rd[15:0]};
            default: o_rdata = w_rd;
        endcase
    end

endmodule

// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - multi-cycle load/store unit; LSU_MISALIGN_SPLIT_EN enables two-beat misaligned accesses
module lsu_split
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e            r_state, w_next;
    logic                  r_we, r_unsigned, r_err, r_split;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata, r_beat0, r_beat1;

    logic                  w_accept, w_misaligned, w_addr_oob, w_req_err;
    logic                  w_mem_req, w_hi_beat, w_resp;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [3:0]            w_be_lo, w_be_hi;
    logic [31:0]           w_wdata_lo, w_wdata_hi, w_rdata;

    assign w_accept     = (r_state == ST_IDLE) && req_valid_i;
    assign w_misaligned = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                          ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
    assign w_addr_oob   = (req_addr_i >> ADDR_WIDTH) != 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_req_err    = (req_size_i == 2'b11) || w_addr_oob;
`else
    assign w_req_err    = (req_size_i == 2'b11) || w_addr_oob || w_misaligned;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_split    <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_beat0    <= 32'd0;
            r_beat1    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we       <= req_we_i;
                r_unsigned <= req_unsigned_i;
                r_size     <= req_size_i;
                r_addr     <= req_addr_i[ADDR_WIDTH-1:0];
                r_wdata    <= req_wdata_i;
                r_err      <= w_req_err;
                r_split    <= w_misaligned && !w_req_err;
                r_beat0    <= 32'd0;
                r_beat1    <= 32'd0;
            end
            if ((r_state == ST_WAIT0) && mem_rvalid_i) r_beat0 <= mem_rdata_i;
            if ((r_state == ST_WAIT1) && mem_rvalid_i) r_beat1 <= mem_rdata_i;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_hi_beat = 1'b0;
        w_resp    = 1'b0;
        case (r_state)
            ST_IDLE:  if (req_valid_i) w_next = w_req_err ? ST_RESP : ST_REQ0;
            ST_REQ0: begin
                w_mem_req = 1'b1;
                if (mem_gnt_i) w_next = ST_WAIT0;
            end
            ST_WAIT0: if (mem_rvalid_i) w_next = r_split ? ST_REQ1 : ST_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_REQ1: begin
                w_mem_req = 1'b1;
                w_hi_beat = 1'b1;
                if (mem_gnt_i) w_next = ST_WAIT1;
            end
            ST_WAIT1: if (mem_rvalid_i) w_next = ST_RESP;
`endif
            ST_RESP: begin
                w_resp = 1'b1;
                w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    lsu_align u_align (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_off      (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_beat0    (r_beat0),
        .i_beat1    (r_beat1),
        .o_be_lo    (w_be_lo),
        .o_be_hi    (w_be_hi),
        .o_wdata_lo (w_wdata_lo),
        .o_wdata_hi (w_wdata_hi),
        .o_rdata    (w_rdata)
    );

    // Second beat wraps at the top of the address space by plain modular addition.
    assign w_word_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign req_ready_o  = (r_state == ST_IDLE);
    assign busy_o       = (r_state != ST_IDLE);
    assign mem_req_o    = w_mem_req;
    assign mem_we_o     = w_mem_req & r_we;
    assign mem_addr_o   = !w_mem_req ? '0 : (w_hi_beat ? w_word_addr + ADDR_WIDTH'(4) : w_word_addr);
    assign mem_be_o     = !w_mem_req ? 4'b0000 : (w_hi_beat ? w_be_hi : w_be_lo);
    assign mem_wdata_o  = !w_mem_req ? 32'd0 : (w_hi_beat ? w_wdata_hi : w_wdata_lo);
    assign resp_valid_o = w_resp;
    assign resp_err_o   = w_resp & r_err;
    assign resp_rdata_o = (w_resp && !r_we && !r_err) ? w_rdata : 32'd0;

endmodule

// File: tb/tb_lsu_split.sv
// tb/tb_lsu_split.sv - directed bench for lsu_split with a byte-level reference model; honours LSU_MISALIGN_SPLIT_EN
module tb_lsu_split;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT = 1'b1;
`else
    localparam logic SPLIT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_err_o, busy_o;
    logic [31:0] resp_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;

    lsu_split #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .busy_o(busy_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    logic [31:0] mem [0:1023];

    logic [11:0] qb_addr [$];
    logic [3:0]  qb_be   [$];
    logic        qb_we   [$];
    logic [31:0] qb_wd   [$];
    logic        qr_err  [$];
    logic [31:0] qr_rd   [$];
    int          qr_lat  [$];

    int          acc_t;
    int          nobs;
    int          last_lat;
    logic        last_err;
    logic [31:0] last_rdata;
    logic [11:0] obs_addr [2];
    logic [3:0]  obs_be   [2];
    logic [31:0] obs_wd   [2];

    initial forever begin
        @(negedge clk_i);
        if (!rst_i) begin
            if (mem_req_o) begin
                if (qb_addr.size() == 0) chk("unexp_mem_req", 32'd1, 32'd0);
                else begin
                    logic [31:0] m;
                    m = {{8{qb_be[0][3]}}, {8{qb_be[0][2]}}, {8{qb_be[0][1]}}, {8{qb_be[0][0]}}};
                    chk("mem_addr", 32'(mem_addr_o), 32'(qb_addr[0]));
                    chk("mem_be", 32'(mem_be_o), 32'(qb_be[0]));
                    chk("mem_we", 32'(mem_we_o), 32'(qb_we[0]));
                    if (qb_we[0]) chk("mem_wdata", mem_wdata_o & m, qb_wd[0] & m);
                    if (mem_gnt_i) begin
                        if (nobs < 2) begin
                            obs_addr[nobs] = mem_addr_o;
                            obs_be[nobs]   = mem_be_o;
                            obs_wd[nobs]   = mem_wdata_o;
                        end
                        nobs++;
                        void'(qb_addr.pop_front()); void'(qb_be.pop_front());
                        void'(qb_we.pop_front());   void'(qb_wd.pop_front());
                    end
                end
            end
            if (resp_valid_o) begin
                if (qr_err.size() == 0) chk("unexp_resp", 32'd1, 32'd0);
                else begin
                    chk("resp_err", 32'(resp_err_o), 32'(qr_err[0]));
                    chk("resp_rdata", resp_rdata_o, qr_rd[0]);
                    chk("resp_latency", 32'(cyc - acc_t), 32'(qr_lat[0]));
                    last_lat   = cyc - acc_t;
                    last_err   = resp_err_o;
                    last_rdata = resp_rdata_o;
                    void'(qr_err.pop_front()); void'(qr_rd.pop_front()); void'(qr_lat.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Byte-by-byte reference: each byte of the access lands in word (addr+i)/4, lane (addr+i)%4.
    task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gnt_wait, input logic spur);
        logic        err, mis;
        int          nb, nbytes, n;
        logic [3:0]  be  [2];
        logic [31:0] bwd [2];
        logic [9:0]  wrd [2];
        logic [31:0] rd;
        mis = ((sz == 2'b01) && addr[0]) || ((sz == 2'b10) && (addr[1:0] != 2'b00));
        err = (sz == 2'b11) || (addr[31:12] != 20'd0) || (mis && !SPLIT);
        be[0] = 4'd0; be[1] = 4'd0; bwd[0] = 32'd0; bwd[1] = 32'd0; rd = 32'd0;
        wrd[0] = addr[11:2];
        wrd[1] = addr[11:2] + 10'd1;
        nb = 0;
        if (!err) begin
            nbytes = 1 << sz;
            for (int i = 0; i < nbytes; i++) begin
                logic [11:0] ba;
                int b, ln;
                ba = addr[11:0] + 12'(i);
                b  = (ba[11:2] == wrd[0]) ? 0 : 1;
                ln = int'(ba[1:0]);
                be[b][ln] = 1'b1;
                bwd[b][8*ln +: 8] = wd[8*i +: 8];
                rd[8*i +: 8] = mem[ba[11:2]][8*ln +: 8];
            end
            nb = (be[1] != 4'd0) ? 2 : 1;
            if (!uns && nbytes < 4 && rd[8*nbytes-1]) rd = rd | ~((32'd1 << (8*nbytes)) - 32'd1);
            if (we) rd = 32'd0;
        end
        for (int b = 0; b < nb; b++) begin
            qb_addr.push_back({wrd[b], 2'b00});
            qb_be.push_back(be[b]);
            qb_we.push_back(we);
            qb_wd.push_back(bwd[b]);
        end
        qr_err.push_back(err);
        qr_rd.push_back(rd);
        qr_lat.push_back(err ? 1 : 1 + nb * (2 + gnt_wait));
        nobs = 0;
        for (int b = 0; b < 2; b++) begin
            obs_addr[b] = 12'hFFF; obs_be[b] = 4'd0; obs_wd[b] = 32'd0;
        end
        req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wd; req_valid_i = 1'b1;
        acc_t = cyc;
        tick();
        req_valid_i = 1'b0;
        for (int b = 0; b < nb; b++) begin
            n = 0;
            while (!mem_req_o && n < 10) begin tick(); n++; end
            if (!mem_req_o) begin
                chk("mem_req_timeout", 32'd0, 32'd1);
                break;
            end
            for (int k = 0; k < gnt_wait; k++) begin
                mem_rvalid_i = spur;
                mem_rdata_i  = 32'hBAD0BAD0;
                tick();
            end
            mem_rvalid_i = 1'b0;
            mem_gnt_i    = 1'b1;
            if (we) for (int l = 0; l < 4; l++) if (be[b][l]) mem[wrd[b]][8*l +: 8] = bwd[b][8*l +: 8];
            tick();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem[wrd[b]];
            tick();
            mem_rvalid_i = 1'b0;
        end
        n = 0;
        while (qr_err.size() != 0 && n < 20) begin tick(); n++; end
        if (qr_err.size() != 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            qr_err.delete(); qr_rd.delete(); qr_lat.delete();
        end
        qb_addr.delete(); qb_be.delete(); qb_we.delete(); qb_wd.delete();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_resp_err", 32'(resp_err_o), 32'd0);
        chk("rst_resp_rdata", resp_rdata_o, 32'd0);

        run_access(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 0, 1'b0);
        chk("sw_lat", 32'(last_lat), 32'd3);
        chk("sw_addr", 32'(obs_addr[0]), 32'h010);
        chk("sw_be", 32'(obs_be[0]), 32'hF);
        chk("sw_wdata", obs_wd[0], 32'hDEADBEEF);

        mem[4] = 32'h80000000;
        run_access(1'b0, 2'b00, 1'b0, 32'h013, 32'd0, 0, 1'b0);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        chk("lb_be", 32'(obs_be[0]), 32'h8);
        run_access(1'b0, 2'b00, 1'b1, 32'h013, 32'd0, 0, 1'b0);
        chk("lbu_rdata", last_rdata, 32'h00000080);

        mem[0] = 32'hAB000000; mem[1] = 32'h000000CD;
        run_access(1'b0, 2'b01, 1'b1, 32'h003, 32'd0, 0, 1'b0);
        chk("lhu_split_rdata", last_rdata, SPLIT ? 32'h0000CDAB : 32'd0);
        chk("lhu_split_err", 32'(last_err), SPLIT ? 32'd0 : 32'd1);
        chk("lhu_split_lat", 32'(last_lat), SPLIT ? 32'd5 : 32'd1);
        chk("lhu_split_beats", 32'(nobs), SPLIT ? 32'd2 : 32'd0);
        chk("lhu_b1_addr", 32'(obs_addr[1]), SPLIT ? 32'h004 : 32'hFFF);
        chk("lhu_b1_be", 32'(obs_be[1]), SPLIT ? 32'h1 : 32'h0);

        run_access(1'b1, 2'b10, 1'b0, 32'h006, 32'h12345678, 0, 1'b0);
        chk("sw_split_b0_be", 32'(obs_be[0]), SPLIT ? 32'hC : 32'h0);
        chk("sw_split_b0_wd", obs_wd[0], SPLIT ? 32'h56780000 : 32'h0);
        chk("sw_split_b1_addr", 32'(obs_addr[1]), SPLIT ? 32'h008 : 32'hFFF);
        chk("sw_split_b1_wd", obs_wd[1], SPLIT ? 32'h00001234 : 32'h0);

        mem[8] = 32'h11223344;
        run_access(1'b0, 2'b10, 1'b0, 32'h020, 32'd0, 3, 1'b1);
        chk("stall_rdata", last_rdata, 32'h11223344);
        chk("stall_lat", 32'(last_lat), 32'd6);

        run_access(1'b1, 2'b01, 1'b0, 32'h00A, 32'h0000BEEF, 0, 1'b0);
        chk("sh_wdata", obs_wd[0] & 32'hFFFF0000, 32'hBEEF0000);
        run_access(1'b0, 2'b01, 1'b0, 32'h00A, 32'd0, 1, 1'b0);
        chk("lh_rdata", last_rdata, 32'hFFFFBEEF);

        run_access(1'b0, 2'b11, 1'b0, 32'h030, 32'd0, 0, 1'b0);
        chk("illegal_size_err", 32'(last_err), 32'd1);
        run_access(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 0, 1'b0);
        chk("oob_err", 32'(last_err), 32'd1);
        chk("oob_lat", 32'(last_lat), 32'd1);
        chk("oob_beats", 32'(nobs), 32'd0);

        mem[1023] = 32'hA1B2C3D4;
        run_access(1'b0, 2'b10, 1'b0, 32'hFFE, 32'd0, 0, 1'b0);
        chk("wrap_rdata", last_rdata, SPLIT ? 32'h0000A1B2 : 32'd0);
        chk("wrap_b1_addr", 32'(obs_addr[1]), SPLIT ? 32'h000 : 32'hFFF);

        // Abort a load in WAIT0, then deliver its rvalid late.
        qb_addr.push_back(12'h020); qb_be.push_back(4'hF); qb_we.push_back(1'b0); qb_wd.push_back(32'd0);
        req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h020; req_valid_i = 1'b1;
        acc_t = cyc;
        tick();
        req_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55555555;
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_mem_req", 32'(mem_req_o), 32'd0);
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        tick();
        mem_rvalid_i = 1'b0;
        repeat (4) tick();
        chk("abort_beats_left", 32'(qb_addr.size()), 32'd0);

        run_access(1'b0, 2'b10, 1'b0, 32'h020, 32'd0, 0, 1'b0);
        chk("post_abort_rdata", last_rdata, 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
